instr_buffer: RTL and testbench
===============================

# instr_buffer

Instruction fetch queue between the fetch unit and the decoder. Stores fetched 32-bit instructions with their 64-bit PCs in a circular buffer. Presents the oldest entry to the decoder first-word-fall-through on `fifo_data_out`/`fifo_empty`. Supports a single-cycle flush on pipeline redirect.

## Interface
- `DEPTH`, default 8: number of entries. Must be a power of 2 and ≥2.
- `PTR_W`, default $clog2(DEPTH): index width. Pointers carry one extra wrap bit.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  redirect; discards all entries.
- `fetch_valid`  in  1  fetch presents an instruction.
- `fetch_instr`  in  32  instruction word.
- `fetch_pc`  in  64  PC of `fetch_instr`.
- `fetch_ready`  out  1  buffer can accept a push.
- `fifo_read_en`  in  1  decoder consumes the head entry.
- `fifo_empty`  out  1  no valid entry at head.
- `fifo_data_out`  out  32  head instruction.
- `fifo_pc_out`  out  64  head PC.
- `fifo_count`  out  PTR_W+1  number of valid entries, 0..DEPTH.

## Operation
- **Storage:** `DEPTH` × {instr[31:0], pc[63:0]} register array, not reset. Write pointer `wptr` and read pointer `rptr` are each PTR_W+1 bits and wrap modulo 2·DEPTH.
- **Status flags:**
  - empty = (`wptr` == `rptr`).
  - full = index bits equal and wrap bits differ.
  - `fifo_count` = `wptr` − `rptr`, computed in PTR_W+1 bits.
- **Push:** `push = fetch_valid & fetch_ready & !flush`. On push, write entry at `wptr[PTR_W-1:0]` and increment `wptr`.
- **Pop:** `pop = fifo_read_en & !fifo_empty & !flush`. On pop, increment `rptr`. `fifo_read_en` while empty is ignored with no state change.
- **Ready:** `fetch_ready = !full`, combinational from the registered pointers. `fetch_ready` does not depend on `fifo_read_en`. When full, a same-cycle pop does not enable a push.
- **Simultaneous push and pop** (not full, not empty): both pointers advance and `fifo_count` is unchanged.
- **Push into empty:** that cycle's push is not visible at the head. It appears on the next cycle.
- **Flush:** highest priority. At the next edge `wptr` = `rptr` = 0, so count is 0. Any same-cycle push or pop is discarded. `fetch_ready` stays as computed from the current pointers during the flush cycle.
- **Head outputs:**
  - Not empty: `fifo_data_out` = mem[`rptr` index] and `fifo_pc_out` = matching pc, driven combinationally.
  - Empty: `fifo_data_out` = 32'h0000_0013 (NOP) and `fifo_pc_out` = 64'h0.
- **Pointer wrap:** index wraps from DEPTH−1 to 0 and the wrap bit toggles. There is no other special case.

## Timing
- **Reset (async assert, sync deassert by the system):** `wptr` = `rptr` = 0, `fifo_empty` = 1, `fetch_ready` = 1, `fifo_count` = 0, `fifo_data_out` = 32'h13, `fifo_pc_out` = 0. Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- **Push-to-visible latency:** 1 cycle. An entry pushed at edge N is at the head from edge N onward if the buffer was empty.
- **Pop:** the head advances at the edge where `pop` is sampled. The next entry, or the empty NOP, is visible right after that edge.
- **Flush:** `fifo_empty` = 1 and `fetch_ready` = 1 from the edge following the `flush` cycle.
- **Throughput:** 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- **Combinational paths:** `fifo_*` outputs and `fetch_ready` are pure functions of registered state and the memory array. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and head-on-empty:** Assert `reset_n`=0 mid-stream after 3 pushes. Required: `fifo_empty`=1, `fifo_count`=0, `fifo_data_out`=32'h13 and `fifo_pc_out`=0 without a clock edge. After release, `fetch_ready`=1.
- **Fill to full:** Push 8 instructions 32'h00100093+k with pc 64'h8000_0000+4k (DEPTH=8) and no pops. Required: `fifo_count`=8 and `fetch_ready`=0. A 9th `fetch_valid` is dropped and the head stays 32'h00100093 / 64'h8000_0000.
- **Wrap-around streaming:** Push and pop simultaneously for 20 cycles starting from count=3. Required: `fifo_count` stays 3 and pops return instructions in exact push order across two pointer wraps.
- **Full with pop:** At count=8, assert `fetch_valid` and `fifo_read_en` together. Required: pop accepted, push rejected, count becomes 7. `fetch_ready`=1 on the next cycle.
- **Flush priority:** At count=5, assert `flush`, `fetch_valid` and `fifo_read_en` together. Required: next cycle count=0, `fifo_empty`=1, `fifo_data_out`=32'h13. The flush-cycle instruction never appears at the head.
- **Pop on empty:** Assert `fifo_read_en` for 3 cycles while empty, then push one instruction 32'h00000513 pc 64'h8000_0010. Required: pointers unchanged during the idle pops. The head shows 32'h00000513 / 64'h8000_0010 and count=1.

Source files
------------

// File: rtl/instr_buffer.sv
// Instruction fetch queue: circular buffer of {instr, pc} between fetch and decode.
// Head is presented first-word-fall-through; a flush empties the queue in one cycle.
module instr_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               fetch_valid,
   input  logic [31:0]        fetch_instr,
   input  logic [63:0]        fetch_pc,
   output logic               fetch_ready,
   input  logic               fifo_read_en,
   output logic               fifo_empty,
   output logic [31:0]        fifo_data_out,
   output logic [63:0]        fifo_pc_out,
   output logic [PTR_W:0]     fifo_count
);

   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
   localparam logic [31:0]    NOP     = 32'h0000_0013;

   logic [31:0]    r_memInstr [DEPTH];
   logic [63:0]    r_memPc    [DEPTH];
   logic [PTR_W:0] r_wptr;
   logic [PTR_W:0] r_rptr;

   logic           w_empty;
   logic           w_full;
   logic           w_push;
   logic           w_pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]) &&
                    (r_wptr[PTR_W] != r_rptr[PTR_W]);

   assign w_push = fetch_valid && !w_full && !flush;
   assign w_pop  = fifo_read_en && !w_empty && !flush;

   assign fetch_ready = !w_full;
   assign fifo_empty  = w_empty;
   assign fifo_count  = r_wptr - r_rptr;

   assign fifo_data_out = w_empty ? NOP   : r_memInstr[r_rptr[PTR_W-1:0]];
   assign fifo_pc_out   = w_empty ? 64'h0 : r_memPc[r_rptr[PTR_W-1:0]];

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_memInstr[r_wptr[PTR_W-1:0]] <= fetch_instr;
         r_memPc[r_wptr[PTR_W-1:0]]    <= fetch_pc;
      end
   end

   // Flush overrides any same-cycle push or pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer with a queue scoreboard of pushed entries.
module tb_instr_buffer;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic           clock;
   logic           reset_n;
   logic           flush;
   logic           fetch_valid;
   logic [31:0]    fetch_instr;
   logic [63:0]    fetch_pc;
   logic           fetch_ready;
   logic           fifo_read_en;
   logic           fifo_empty;
   logic [31:0]    fifo_data_out;
   logic [63:0]    fifo_pc_out;
   logic [PTR_W:0] fifo_count;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } entry_t;

   entry_t sbQ[$];
   int     checks = 0;
   int     errors = 0;

   instr_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .flush(flush),
      .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr),
      .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready),
      .fifo_read_en(fifo_read_en),
      .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out),
      .fifo_pc_out(fifo_pc_out),
      .fifo_count(fifo_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the scoreboard contents.
   task automatic checkState(input string tag);
      checkOutput({tag, " count"}, 64'(fifo_count), 64'(sbQ.size()));
      checkOutput({tag, " empty"}, 64'(fifo_empty), (sbQ.size() == 0) ? 64'd1 : 64'd0);
      checkOutput({tag, " ready"}, 64'(fetch_ready), (sbQ.size() < DEPTH) ? 64'd1 : 64'd0);
      if (sbQ.size() == 0) begin
         checkOutput({tag, " head instr"}, 64'(fifo_data_out), 64'h13);
         checkOutput({tag, " head pc"}, fifo_pc_out, 64'h0);
      end else begin
         checkOutput({tag, " head instr"}, 64'(fifo_data_out), 64'(sbQ[0].instr));
         checkOutput({tag, " head pc"}, fifo_pc_out, sbQ[0].pc);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic valid, input logic [31:0] instr,
                                input logic [63:0] pc, input logic rd, input logic fl);
      bit modelFull;
      bit doPop;
      bit doPush;
      entry_t e;
      @(negedge clock);
      fetch_valid  = valid;
      fetch_instr  = instr;
      fetch_pc     = pc;
      fifo_read_en = rd;
      flush        = fl;
      #1;
      if (fl) begin
         sbQ.delete();
      end else begin
         modelFull = (sbQ.size() == DEPTH);
         doPop     = rd && (sbQ.size() != 0);
         doPush    = valid && !modelFull;
         if (doPop) begin
            checkOutput({tag, " pop instr"}, 64'(fifo_data_out), 64'(sbQ[0].instr));
            checkOutput({tag, " pop pc"}, fifo_pc_out, sbQ[0].pc);
            void'(sbQ.pop_front());
         end
         if (doPush) begin
            e.instr = instr;
            e.pc    = pc;
            sbQ.push_back(e);
         end
      end
      @(posedge clock);
      #1;
      fetch_valid  = 1'b0;
      fifo_read_en = 1'b0;
      flush        = 1'b0;
      checkState(tag);
   endtask

   initial begin
      reset_n      = 1'b0;
      flush        = 1'b0;
      fetch_valid  = 1'b0;
      fetch_instr  = '0;
      fetch_pc     = '0;
      fifo_read_en = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      checkState("reset");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checkState("post-reset");

      $display("[TB] async reset mid-stream");
      for (int k = 0; k < 3; k++)
         applyStimulus("pre-reset push", 1'b1, 32'h1111_0000 + k, 64'h4000_0000 + 4*k, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      sbQ.delete();
      checkOutput("async reset count", 64'(fifo_count), 64'd0);
      checkOutput("async reset empty", 64'(fifo_empty), 64'd1);
      checkOutput("async reset instr", 64'(fifo_data_out), 64'h13);
      checkOutput("async reset pc", fifo_pc_out, 64'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checkState("reset release");

      $display("[TB] fill to full");
      for (int k = 0; k < DEPTH; k++)
         applyStimulus("fill", 1'b1, 32'h0010_0093 + k, 64'h8000_0000 + 4*k, 1'b0, 1'b0);
      checkOutput("full count", 64'(fifo_count), 64'd8);
      checkOutput("full ready", 64'(fetch_ready), 64'd0);
      applyStimulus("ninth push", 1'b1, 32'hBAD0_0001, 64'hBAD0, 1'b0, 1'b0);
      checkOutput("full head instr", 64'(fifo_data_out), 64'h0010_0093);
      checkOutput("full head pc", fifo_pc_out, 64'h8000_0000);

      $display("[TB] full with pop");
      applyStimulus("full pop+push", 1'b1, 32'hBAD0_0002, 64'hBAD4, 1'b1, 1'b0);
      checkOutput("after full pop count", 64'(fifo_count), 64'd7);
      checkOutput("after full pop ready", 64'(fetch_ready), 64'd1);

      $display("[TB] wrap-around streaming");
      for (int k = 0; k < 4; k++)
         applyStimulus("drain", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++)
         applyStimulus("stream", 1'b1, 32'hA000_0000 + k, 64'h9000_0000 + 4*k, 1'b1, 1'b0);
      checkOutput("stream count", 64'(fifo_count), 64'd3);

      $display("[TB] flush priority");
      applyStimulus("to five a", 1'b1, 32'hB000_0001, 64'hB004, 1'b0, 1'b0);
      applyStimulus("to five b", 1'b1, 32'hB000_0002, 64'hB008, 1'b0, 1'b0);
      checkOutput("pre-flush count", 64'(fifo_count), 64'd5);
      applyStimulus("flush", 1'b1, 32'hDEAD_BEEF, 64'hDEAD, 1'b1, 1'b1);
      checkOutput("flush instr", 64'(fifo_data_out), 64'h13);
      applyStimulus("post-flush idle", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

      $display("[TB] pop on empty");
      for (int k = 0; k < 3; k++)
         applyStimulus("idle pop", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      applyStimulus("push after idle", 1'b1, 32'h0000_0513, 64'h8000_0010, 1'b0, 1'b0);
      checkOutput("single head instr", 64'(fifo_data_out), 64'h0000_0513);
      checkOutput("single head pc", fifo_pc_out, 64'h8000_0010);
      checkOutput("single count", 64'(fifo_count), 64'd1);
      applyStimulus("final pop", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
